wb_master_engine: RTL and testbench

Wishbone B4 initiator that turns single commands into bus cycles toward slaves such as the register slave. Supported cycle types: classic single read/write, pipelined single read/write, and read-modify-write. A simple valid/ready command port sits on the CPU/test side; the Wishbone master port drives the slave. Each command produces exactly one response pulse carrying read data and ACK/ERR status.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_timeout_counter.sv | 35 +++
 rtl/wb_master_engine.sv | 216 +++++++++++++++++++++
 tb/tb_wb_master_engine.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the Wishbone master engine: command opcodes, response codes and FSM states.
package wb_pkg;

    typedef enum logic [2:0] {
        OpClassicRd = 3'd0,
        OpClassicWr = 3'd1,
        OpRmw       = 3'd2,
        OpPipeRd    = 3'd3,
        OpPipeWr    = 3'd4
    } op_t;

    typedef enum logic {
        RETURN_ACK = 1'b0,
        RETURN_ERR = 1'b1
    } ret_t;

    typedef enum logic [2:0] {
        StIdle,
        StClassic,
        StPipeReq,
        StPipeWait,
        StRmwRd,
        StRmwWr,
        StResp
    } state_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Wait-cycle watchdog for the Wishbone master: restarted on each wait-state entry, stopped on
// completion, flags expiry in the last allowed wait cycle. Used only with WB_MASTER_TIMEOUT_EN.
module wb_timeout_counter #(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CntW-1:0] r_cnt;
    logic            r_run;

    assign expired_o = r_run && (r_cnt == CntW'(CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start_i) begin
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (clear_i) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (r_run && !expired_o) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/wb_master_engine.sv
// Wishbone B4 master engine: one command -> one classic, pipelined or RMW bus cycle -> one response.
// Define WB_MASTER_TIMEOUT_EN to abort a cycle with ERR after TIMEOUT_CYCLES wait cycles.
module wb_master_engine #(
    parameter int unsigned  ADDR_WIDTH     = 16,
    parameter int unsigned  DATA_WIDTH     = 32,
    parameter int unsigned  GRANULE        = 8,
    parameter int unsigned  TIMEOUT_CYCLES = 16,
    localparam int unsigned SEL_WIDTH      = DATA_WIDTH / GRANULE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [2:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_ret_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [SEL_WIDTH-1:0]  sel_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,
    input  logic                  err_i,
    input  logic                  stall_i
);

    import wb_pkg::*;

    state_t                r_state, w_state_d;
    logic                  r_cyc, w_cyc_d;
    logic                  r_stb, w_stb_d;
    logic                  r_we, w_we_d;
    logic [ADDR_WIDTH-1:0] r_adr, w_adr_d;
    logic [SEL_WIDTH-1:0]  r_sel, w_sel_d;
    logic [DATA_WIDTH-1:0] r_dat, w_dat_d;
    logic                  r_rsp_valid, w_rsp_valid_d;
    logic [DATA_WIDTH-1:0] r_rsp_dat, w_rsp_dat_d;
    ret_t                  r_rsp_ret, w_rsp_ret_d;

    logic w_accept, w_op_valid, w_resp_in;
    logic w_fin, w_fin_err, w_capture, w_tmo_start, w_timeout;

    assign cmd_ready_o = (r_state == StIdle) && rst_i;
    assign w_accept    = cmd_valid_i && cmd_ready_o;
    assign w_op_valid  = (cmd_op_i <= OpPipeWr);
    assign w_resp_in   = ack_i || err_i;

    always_comb begin
        w_state_d     = r_state;
        w_cyc_d       = r_cyc;
        w_stb_d       = r_stb;
        w_we_d        = r_we;
        w_adr_d       = r_adr;
        w_sel_d       = r_sel;
        w_dat_d       = r_dat;
        w_rsp_valid_d = 1'b0;
        w_rsp_dat_d   = r_rsp_dat;
        w_rsp_ret_d   = r_rsp_ret;
        w_fin         = 1'b0;
        w_fin_err     = 1'b0;
        w_capture     = 1'b0;
        w_tmo_start   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_accept && !w_op_valid) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end else if (w_accept) begin
                    w_cyc_d     = 1'b1;
                    w_stb_d     = 1'b1;
                    w_we_d      = (cmd_op_i == OpClassicWr) || (cmd_op_i == OpPipeWr);
                    w_adr_d     = cmd_adr_i;
                    w_sel_d     = cmd_sel_i;
                    w_dat_d     = cmd_dat_i;
                    w_tmo_start = 1'b1;
                    if (cmd_op_i == OpRmw) begin
                        w_state_d = StRmwRd;
                    end else if ((cmd_op_i == OpPipeRd) || (cmd_op_i == OpPipeWr)) begin
                        w_state_d = StPipeReq;
                    end else begin
                        w_state_d = StClassic;
                    end
                end
            end
            StClassic, StPipeWait: begin
                if (w_resp_in) begin
                    w_fin     = 1'b1;
                    w_fin_err = err_i;
                    w_capture = !r_we;
                end else if (w_timeout) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            StPipeReq: begin
                // A response in the transfer cycle itself completes without visiting PIPE_WAIT.
                if (!stall_i) begin
                    if (w_resp_in) begin
                        w_fin     = 1'b1;
                        w_fin_err = err_i;
                        w_capture = !r_we;
                    end else begin
                        w_stb_d     = 1'b0;
                        w_state_d   = StPipeWait;
                        w_tmo_start = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            StRmwRd: begin
                if (err_i) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end else if (ack_i) begin
                    w_rsp_dat_d = dat_i;
                    w_we_d      = 1'b1;
                    w_state_d   = StRmwWr;
                    w_tmo_start = 1'b1;
                end else if (w_timeout) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            StRmwWr: begin
                if (w_resp_in) begin
                    w_fin     = 1'b1;
                    w_fin_err = err_i;
                end else if (w_timeout) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            StResp: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        if (w_fin) begin
            w_state_d     = StResp;
            w_cyc_d       = 1'b0;
            w_stb_d       = 1'b0;
            w_we_d        = 1'b0;
            w_rsp_valid_d = 1'b1;
            w_rsp_ret_d   = w_fin_err ? RETURN_ERR : RETURN_ACK;
            if (w_capture && !w_fin_err) begin
                w_rsp_dat_d = dat_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= StIdle;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_sel       <= '0;
            r_dat       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_ret   <= RETURN_ACK;
        end else begin
            r_state     <= w_state_d;
            r_cyc       <= w_cyc_d;
            r_stb       <= w_stb_d;
            r_we        <= w_we_d;
            r_adr       <= w_adr_d;
            r_sel       <= w_sel_d;
            r_dat       <= w_dat_d;
            r_rsp_valid <= w_rsp_valid_d;
            r_rsp_dat   <= w_rsp_dat_d;
            r_rsp_ret   <= w_rsp_ret_d;
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    wb_timeout_counter #(
        .CYCLES    (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (w_tmo_start),
        .clear_i   (w_fin),
        .expired_o (w_timeout)
    );
`else
    // Without the watchdog the engine waits for ack_i/err_i indefinitely.
    logic w_unused_tmo;
    assign w_timeout    = 1'b0;
    assign w_unused_tmo = ^{w_tmo_start, TIMEOUT_CYCLES};
`endif

    assign cyc_o       = r_cyc;
    assign stb_o       = r_stb;
    assign we_o        = r_we;
    assign adr_o       = r_adr;
    assign sel_o       = r_sel;
    assign dat_o       = r_dat;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_ret_o   = r_rsp_ret;

endmodule

// File: tb/tb_wb_master_engine.sv
// Bench for wb_master_engine: directed test-plan cases plus randomized commands, checked against a
// transaction-level model of response code, read data, latency and bus shape.
module tb_wb_master_engine;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [2:0]    cmd_op_i = '0;
    logic [AW-1:0] cmd_adr_i = '0;
    logic [SW-1:0] cmd_sel_i = '0;
    logic [DW-1:0] cmd_dat_i = '0;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_dat_o;
    logic          rsp_ret_o;
    logic          cyc_o, stb_o, we_o;
    logic [AW-1:0] adr_o;
    logic [SW-1:0] sel_o;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] dat_i = '0;
    logic          ack_i = 1'b0;
    logic          err_i = 1'b0;
    logic          stall_i = 1'b0;

    always #5 clk = ~clk;

    wb_master_engine #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .GRANULE        (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_sel_i   (cmd_sel_i),
        .cmd_dat_i   (cmd_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_ret_o   (rsp_ret_o),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .we_o        (we_o),
        .adr_o       (adr_o),
        .sel_o       (sel_o),
        .dat_o       (dat_o),
        .dat_i       (dat_i),
        .ack_i       (ack_i),
        .err_i       (err_i),
        .stall_i     (stall_i)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] m_rdat = '0;  // model: last successfully read data

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // e0: error on the (first) data phase, e1: error on the RMW write phase,
    // both: drive ack_i together with err_i when erroring.
    task automatic run_cmd(input logic [2:0] op, input logic [15:0] adr, input logic [3:0] sel,
                           input logic [31:0] wdat, input logic [31:0] rdat, input bit e0,
                           input bit e1, input bit both, input int stall, input int lat,
                           input string tag);
        bit          pipe, is_wr, got, exp_we, e;
        int          phase, dly, stall_left, wait_left, stb_n, cyc_n, bad, rsp_k, exp_lat;
        logic        exp_ret, r_ret;
        logic [31:0] r_dat;
        pipe  = (op == 3'd3) || (op == 3'd4);
        is_wr = (op == 3'd1) || (op == 3'd4);
        got = 0; phase = 0; dly = 0; stall_left = stall; wait_left = 0;
        stb_n = 0; cyc_n = 0; bad = 0; rsp_k = 0; r_ret = 1'b0; r_dat = '0;
        if (op > 3'd4) begin
            exp_ret = 1'b1;
            exp_lat = 1;
        end else if (op == 3'd2) begin
            exp_ret = e0 | e1;
            exp_lat = e0 ? 2 + lat : 3 + 2 * lat;
            if (!e0) m_rdat = rdat;
        end else begin
            exp_ret = e0;
            exp_lat = pipe ? 2 + stall + lat : 2 + lat;
            if (!e0 && !is_wr) m_rdat = rdat;
        end

        @(negedge clk);
        check({tag, ".ready"}, {31'b0, cmd_ready_o}, 32'd1);
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_adr_i = adr; cmd_sel_i = sel; cmd_dat_i = wdat;
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        for (int k = 1; k <= 64 && !got; k++) begin
            @(negedge clk);
            ack_i = 1'b0; err_i = 1'b0; stall_i = 1'b0; dat_i = $urandom;
            if (rsp_valid_o) begin
                got = 1; rsp_k = k; r_ret = rsp_ret_o; r_dat = rsp_dat_o;
            end
            if (!cyc_o) begin
                // Bus responses with cyc_o low must be ignored.
                ack_i = 1'($urandom_range(0, 1));
                err_i = 1'($urandom_range(0, 1));
            end else begin
                cyc_n++;
                if (adr_o !== adr || sel_o !== sel) bad++;
                if (stb_o) begin
                    stb_n++;
                    exp_we = (op == 3'd2) ? (phase == 1) : is_wr;
                    if (we_o !== exp_we || (exp_we && dat_o !== wdat)) bad++;
                    if (pipe) begin
                        if (stall_left > 0) begin
                            stall_i = 1'b1;
                            stall_left--;
                        end else if (lat == 0) begin
                            err_i = e0; ack_i = !e0 | both; dat_i = rdat;
                        end else begin
                            wait_left = lat;
                        end
                    end else if (dly == lat) begin
                        e = (phase == 0) ? e0 : e1;
                        err_i = e; ack_i = !e | both; dat_i = rdat;
                        dly = 0;
                        phase++;
                    end else begin
                        dly++;
                    end
                end else if (pipe && wait_left > 0) begin
                    wait_left--;
                    if (wait_left == 0) begin
                        err_i = e0; ack_i = !e0 | both; dat_i = rdat;
                    end
                end
            end
        end
        ack_i = 1'b0; err_i = 1'b0; stall_i = 1'b0;
        check({tag, ".got"}, {31'b0, got}, 32'd1);
        check({tag, ".ret"}, {31'b0, r_ret}, {31'b0, exp_ret});
        check({tag, ".rdat"}, r_dat, m_rdat);
        check({tag, ".latency"}, rsp_k, exp_lat);
        check({tag, ".bus"}, bad, 0);
        if (pipe) check({tag, ".stb_cycles"}, stb_n, stall + 1);
        if (op > 3'd4) check({tag, ".no_cyc"}, cyc_n, 0);
        @(negedge clk);
        check({tag, ".idle_gap"}, {31'b0, cyc_o}, 32'd0);
    endtask

    task automatic silent_read();
        int   cyc_n;
        bit   got;
        logic ret;
        logic [31:0] rd;
        cyc_n = 0; got = 0; ret = 1'b0; rd = '0;
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_op_i = 3'd0; cmd_adr_i = 16'h0020; cmd_sel_i = 4'hF;
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (cyc_o) cyc_n++;
            if (rsp_valid_o) begin
                got = 1; ret = rsp_ret_o; rd = rsp_dat_o;
            end
        end
`ifdef WB_MASTER_TIMEOUT_EN
        check("silent.cyc_cycles", cyc_n, TMO);
        check("silent.got", {31'b0, got}, 32'd1);
        check("silent.ret", {31'b0, ret}, 32'd1);
        check("silent.rdat", rd, m_rdat);
`else
        check("silent.cyc_cycles", cyc_n, 100);
        check("silent.got", {31'b0, got}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        m_rdat = '0;
`endif
    endtask

    task automatic reset_mid_read();
        int rsp_n;
        rsp_n = 0;
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_op_i = 3'd0; cmd_adr_i = 16'h0004; cmd_sel_i = 4'hF;
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid.cyc_before", {31'b0, cyc_o}, 32'd1);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid.cyc", {31'b0, cyc_o}, 32'd0);
        check("rst_mid.stb", {31'b0, stb_o}, 32'd0);
        m_rdat = '0;
        @(negedge clk);
        rst_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid_o) rsp_n++;
        end
        check("rst_mid.no_rsp", rsp_n, 0);
        check("rst_mid.rsp_dat", rsp_dat_o, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset.ctrl", {26'b0, cyc_o, stb_o, we_o, rsp_valid_o, rsp_ret_o, cmd_ready_o}, 32'd0);
        check("reset.adr_sel", {12'b0, adr_o, sel_o}, 32'd0);
        check("reset.dat_o", dat_o, 32'd0);
        check("reset.rsp_dat", rsp_dat_o, 32'd0);
        @(negedge clk);
        rst_i = 1'b1;

        run_cmd(3'd0, 16'h0004, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0, 1, "classic_rd");
        run_cmd(3'd1, 16'h0008, 4'h3, 32'h12345678, 32'h0, 1, 0, 0, 0, 1, "classic_wr_err");
        run_cmd(3'd4, 16'h000C, 4'hF, 32'hCAFEF00D, 32'h0, 0, 0, 0, 2, 2, "pipe_wr_stall");
        run_cmd(3'd2, 16'h0010, 4'hF, 32'hA5A5A5A5, 32'h000000FF, 0, 0, 0, 0, 1, "rmw");
        run_cmd(3'd2, 16'h0010, 4'hF, 32'hA5A5A5A5, 32'h11111111, 1, 0, 0, 0, 1, "rmw_rd_err");
        run_cmd(3'd0, 16'h0014, 4'hF, 32'h0, 32'h22222222, 1, 0, 1, 0, 0, "ack_err_both");
        run_cmd(3'd6, 16'h0018, 4'hF, 32'h0, 32'h0, 0, 0, 0, 0, 0, "op6");
        run_cmd(3'd3, 16'h001C, 4'hC, 32'h0, 32'h33334444, 0, 0, 0, 0, 0, "pipe_rd_same_cycle");

        reset_mid_read();
        silent_read();

        for (int i = 0; i < 40; i++) begin
            run_cmd(3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 4),
                    $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
